// File: rtl/fpga_in_debounce_pkg.sv
// Shared board-input constants: bit positions of every pin in the packed 28-bit input vector.
package lotr_pkg;

    localparam int NUM_FPGA_IN         = 28;
    localparam int FPGA_IN_BUTTON_0    = 0;
    localparam int FPGA_IN_BUTTON_1    = 1;
    localparam int FPGA_IN_SWITCH_LSB  = 2;
    localparam int FPGA_IN_SWITCH_MSB  = 11;
    localparam int FPGA_IN_ARDUINO_LSB = 12;
    localparam int FPGA_IN_ARDUINO_MSB = 27;

    localparam int FPGA_IN_SWITCH_W  = FPGA_IN_SWITCH_MSB - FPGA_IN_SWITCH_LSB + 1;
    localparam int FPGA_IN_ARDUINO_W = FPGA_IN_ARDUINO_MSB - FPGA_IN_ARDUINO_LSB + 1;

    typedef logic [NUM_FPGA_IN-1:0] t_fpga_in;

endpackage

// File: rtl/fpga_in_debounce_if.sv
// Raw board pins, their debounced copies and the rise-sticky clear/flag vectors.
interface fpga_in_debounce_if;
    import lotr_pkg::*;

    logic                         Button_0;
    logic                         Button_1;
    logic [FPGA_IN_SWITCH_W-1:0]  Switch;
    logic [FPGA_IN_ARDUINO_W-1:0] Arduino_dg_io;
    logic                         Button_0_Db;
    logic                         Button_1_Db;
    logic [FPGA_IN_SWITCH_W-1:0]  Switch_Db;
    logic [FPGA_IN_ARDUINO_W-1:0] Arduino_dg_io_Db;
    t_fpga_in                     ClearRiseQ;
    t_fpga_in                     RiseStickyQ;

    modport master (
        output Button_0, Button_1, Switch, Arduino_dg_io, ClearRiseQ,
        input  Button_0_Db, Button_1_Db, Switch_Db, Arduino_dg_io_Db, RiseStickyQ
    );

    modport slave (
        input  Button_0, Button_1, Switch, Arduino_dg_io, ClearRiseQ,
        output Button_0_Db, Button_1_Db, Switch_Db, Arduino_dg_io_Db, RiseStickyQ
    );

endinterface

// File: rtl/fpga_in_debounce_bit.sv
// One input bit: 2-flop synchronizer, mismatch counter, stable flop, optional rise-sticky flag.
// Rise-sticky flop built only when LOTR_FPGA_IN_RISE_STICKY_EN is defined.
module fpga_in_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic srst,
    input  logic pin_i,
    input  logic clear_rise_i,
    output logic db_o,
    output logic rise_sticky_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise;

    // Any edge where sync2 agrees with stable drops the count, so only an unbroken mismatch commits.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise     = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                rise     = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign db_o = stable_q;

`ifdef LOTR_FPGA_IN_RISE_STICKY_EN
    logic sticky_q;
    logic sticky_d;

    // A new rise outranks a clear arriving on the same edge.
    always_comb begin
        sticky_d = rise | (sticky_q & ~clear_rise_i);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign rise_sticky_o = sticky_q;
`else
    logic [1:0] unused_sticky_inputs;
    assign unused_sticky_inputs = {clear_rise_i, rise};
    assign rise_sticky_o        = 1'b0;
`endif

endmodule

// File: rtl/fpga_in_debounce.sv
// Debounces all 28 board inputs; each bit handled by its own fpga_in_debounce_bit instance.
// Optional feature macro: LOTR_FPGA_IN_RISE_STICKY_EN (rise-sticky flags; RiseStickyQ reads 0 otherwise).
module fpga_in_debounce
    import lotr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                QClk,
    input  logic                RstQnnnH,
    fpga_in_debounce_if.slave   pins
);

    t_fpga_in in_vec;
    t_fpga_in db_vec;
    t_fpga_in sticky_vec;

    assign in_vec[FPGA_IN_BUTTON_0]                             = pins.Button_0;
    assign in_vec[FPGA_IN_BUTTON_1]                             = pins.Button_1;
    assign in_vec[FPGA_IN_SWITCH_MSB:FPGA_IN_SWITCH_LSB]        = pins.Switch;
    assign in_vec[FPGA_IN_ARDUINO_MSB:FPGA_IN_ARDUINO_LSB]      = pins.Arduino_dg_io;

    generate
        for (genvar gi = 0; gi < NUM_FPGA_IN; gi++) begin : g_bit
            fpga_in_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bit (
                .clk           (QClk),
                .srst          (RstQnnnH),
                .pin_i         (in_vec[gi]),
                .clear_rise_i  (pins.ClearRiseQ[gi]),
                .db_o          (db_vec[gi]),
                .rise_sticky_o (sticky_vec[gi])
            );
        end
    endgenerate

    assign pins.Button_0_Db      = db_vec[FPGA_IN_BUTTON_0];
    assign pins.Button_1_Db      = db_vec[FPGA_IN_BUTTON_1];
    assign pins.Switch_Db        = db_vec[FPGA_IN_SWITCH_MSB:FPGA_IN_SWITCH_LSB];
    assign pins.Arduino_dg_io_Db = db_vec[FPGA_IN_ARDUINO_MSB:FPGA_IN_ARDUINO_LSB];
    assign pins.RiseStickyQ      = sticky_vec;

endmodule
